// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses write/read/ALU frames into register-file and ALU strobes
// and pushes response bytes to the TX FIFO. Define CMD_TIMEOUT_EN to enable the inter-byte timeout.
module uart_cmd_ctrl #(
  parameter int Data_width     = 8,
  parameter int Address_width  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     Ref_clk,
  input  logic                     RST,
  input  logic [Data_width-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     parity_error,
  input  logic                     framing_error,
  output logic [Address_width-1:0] Address,
  output logic [Data_width-1:0]    WrData,
  output logic                     WrEn,
  output logic                     RdEn,
  input  logic [Data_width-1:0]    RdData,
  input  logic                     RdData_Valid,
  output logic                     ALU_EN,
  output logic [3:0]               ALU_FUN,
  input  logic [2*Data_width-1:0]  ALU_OUT,
  input  logic                     OUT_Valid,
  output logic [Data_width-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  input  logic                     FIFO_FULL,
  output logic                     busy
);

  localparam logic [Data_width-1:0] OP_WR      = Data_width'(8'hAA);
  localparam logic [Data_width-1:0] OP_RD      = Data_width'(8'hBB);
  localparam logic [Data_width-1:0] OP_ALU     = Data_width'(8'hCC);
  localparam logic [Data_width-1:0] OP_ALU_NOP = Data_width'(8'hDD);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_ADDR, ST_WR_DATA, ST_RD_ADDR, ST_RD_WAIT, ST_ALU_A,
    ST_ALU_B, ST_ALU_FUN, ST_ALU_WAIT, ST_TX_RD, ST_TX_LO, ST_TX_HI
  } state_e;

  state_e state_q, state_d;

  logic [Address_width-1:0] addr_q, addr_d;
  logic [Data_width-1:0]    wrdata_q, wrdata_d;
  logic                     wren_q, wren_d;
  logic                     rden_q, rden_d;
  logic                     aluen_q, aluen_d;
  logic [3:0]               alufun_q, alufun_d;
  logic [Data_width-1:0]    rdbyte_q, rdbyte_d;
  logic [2*Data_width-1:0]  aluout_q, aluout_d;
  logic [Data_width-1:0]    tx_data;
  logic                     tx_vld;

  logic rx_ok, rx_err, collecting, counted, tmo_hit;

  assign rx_ok  = RX_D_VLD && !parity_error && !framing_error;
  assign rx_err = RX_D_VLD && (parity_error || framing_error);

  // Collect states accept RX bytes; everything else drops them and reports busy.
  assign collecting = (state_q == ST_IDLE)    || (state_q == ST_WR_ADDR) ||
                      (state_q == ST_WR_DATA) || (state_q == ST_RD_ADDR) ||
                      (state_q == ST_ALU_A)   || (state_q == ST_ALU_B)   ||
                      (state_q == ST_ALU_FUN);
  assign counted    = collecting && (state_q != ST_IDLE);

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = counted && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_cnt_d = '0;
    if (counted && !rx_ok && !tmo_hit) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge Ref_clk) begin
    if (RST) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // No timeout in this build; the expression is constant false for any legal parameter.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge Ref_clk) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_ok) begin
          if (RX_P_DATA == OP_WR)           state_d = ST_WR_ADDR;
          else if (RX_P_DATA == OP_RD)      state_d = ST_RD_ADDR;
          else if (RX_P_DATA == OP_ALU)     state_d = ST_ALU_A;
          else if (RX_P_DATA == OP_ALU_NOP) state_d = ST_ALU_FUN;
        end
      end
      ST_WR_ADDR:  if (rx_ok) state_d = ST_WR_DATA;
      ST_WR_DATA:  if (rx_ok) state_d = ST_IDLE;
      ST_RD_ADDR:  if (rx_ok) state_d = ST_RD_WAIT;
      ST_RD_WAIT:  if (RdData_Valid) state_d = ST_TX_RD;
      ST_ALU_A:    if (rx_ok) state_d = ST_ALU_B;
      ST_ALU_B:    if (rx_ok) state_d = ST_ALU_FUN;
      ST_ALU_FUN:  if (rx_ok) state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: if (OUT_Valid) state_d = ST_TX_LO;
      ST_TX_RD:    if (!FIFO_FULL) state_d = ST_IDLE;
      ST_TX_LO:    if (!FIFO_FULL) state_d = ST_TX_HI;
      ST_TX_HI:    if (!FIFO_FULL) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
    if (counted && !rx_ok && (rx_err || tmo_hit)) state_d = ST_IDLE;
  end

  always_comb begin
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    alufun_d = alufun_q;
    rdbyte_d = rdbyte_q;
    aluout_d = aluout_q;
    wren_d   = 1'b0;
    rden_d   = 1'b0;
    aluen_d  = 1'b0;
    tx_data  = '0;
    tx_vld   = 1'b0;
    case (state_q)
      ST_WR_ADDR: if (rx_ok) addr_d = RX_P_DATA[Address_width-1:0];
      ST_WR_DATA: begin
        if (rx_ok) begin
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        if (rx_ok) begin
          addr_d = RX_P_DATA[Address_width-1:0];
          rden_d = 1'b1;
        end
      end
      ST_RD_WAIT: if (RdData_Valid) rdbyte_d = RdData;
      ST_ALU_A: begin
        if (rx_ok) begin
          addr_d   = '0;
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
        end
      end
      ST_ALU_B: begin
        if (rx_ok) begin
          addr_d   = Address_width'(1);
          wrdata_d = RX_P_DATA;
          wren_d   = 1'b1;
        end
      end
      ST_ALU_FUN: begin
        if (rx_ok) begin
          alufun_d = RX_P_DATA[3:0];
          aluen_d  = 1'b1;
        end
      end
      ST_ALU_WAIT: if (OUT_Valid) aluout_d = ALU_OUT;
      ST_TX_RD: begin
        tx_data = rdbyte_q;
        tx_vld  = !FIFO_FULL;
      end
      ST_TX_LO: begin
        tx_data = aluout_q[Data_width-1:0];
        tx_vld  = !FIFO_FULL;
      end
      ST_TX_HI: begin
        tx_data = aluout_q[2*Data_width-1:Data_width];
        tx_vld  = !FIFO_FULL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Ref_clk) begin
    if (RST) begin
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      rden_q   <= 1'b0;
      aluen_q  <= 1'b0;
      alufun_q <= '0;
      rdbyte_q <= '0;
      aluout_q <= '0;
    end else begin
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      rden_q   <= rden_d;
      aluen_q  <= aluen_d;
      alufun_q <= alufun_d;
      rdbyte_q <= rdbyte_d;
      aluout_q <= aluout_d;
    end
  end

  assign Address   = addr_q;
  assign WrData    = wrdata_q;
  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign ALU_EN    = aluen_q;
  assign ALU_FUN   = alufun_q;
  assign TX_P_DATA = tx_data;
  assign TX_D_VLD  = tx_vld;
  assign busy      = !collecting;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame parsing, strobes, TX responses, errors, stalls, reset.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef CMD_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 65535;
`endif

  logic            Ref_clk = 1'b0;
  logic            RST = 1'b1;
  logic [DW-1:0]   RX_P_DATA = '0;
  logic            RX_D_VLD = 1'b0;
  logic            parity_error = 1'b0;
  logic            framing_error = 1'b0;
  logic [AW-1:0]   Address;
  logic [DW-1:0]   WrData;
  logic            WrEn, RdEn, ALU_EN, TX_D_VLD, busy;
  logic [DW-1:0]   RdData = '0;
  logic            RdData_Valid = 1'b0;
  logic [3:0]      ALU_FUN;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic            OUT_Valid = 1'b0;
  logic [DW-1:0]   TX_P_DATA;
  logic            FIFO_FULL = 1'b0;

  uart_cmd_ctrl #(.Data_width(DW), .Address_width(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .Ref_clk(Ref_clk), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .parity_error(parity_error), .framing_error(framing_error), .Address(Address),
    .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn), .RdData(RdData), .RdData_Valid(RdData_Valid),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL), .busy(busy)
  );

  always #5 Ref_clk = ~Ref_clk;

  int cyc = 0;
  always @(posedge Ref_clk) cyc <= cyc + 1;

  logic [AW-1:0] wr_addr_log[$];
  logic [DW-1:0] wr_data_log[$];
  int            wr_cyc_log[$];
  logic [DW-1:0] tx_log[$];
  int            tx_cyc_log[$];
  int            rd_cnt = 0;
  logic [AW-1:0] rd_addr_last = '0;
  int            alu_cnt = 0;
  logic [3:0]    alu_fun_last = '0;

  always @(negedge Ref_clk) begin
    if (WrEn) begin
      wr_addr_log.push_back(Address);
      wr_data_log.push_back(WrData);
      wr_cyc_log.push_back(cyc);
    end
    if (RdEn) begin
      rd_cnt++;
      rd_addr_last = Address;
    end
    if (ALU_EN) begin
      alu_cnt++;
      alu_fun_last = ALU_FUN;
    end
    if (TX_D_VLD) begin
      tx_log.push_back(TX_P_DATA);
      tx_cyc_log.push_back(cyc);
    end
  end

  int n_chk = 0;
  int n_err = 0;
  int last_rx_cyc = 0;
  int vcyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_addr_log.delete();
    wr_data_log.delete();
    wr_cyc_log.delete();
    tx_log.delete();
    tx_cyc_log.delete();
    rd_cnt  = 0;
    alu_cnt = 0;
  endtask

  // Called at posedge+1; consecutive calls produce back-to-back RX_D_VLD cycles.
  task automatic send_byte(input logic [7:0] b, input logic perr = 1'b0, input logic ferr = 1'b0);
    RX_P_DATA     = b;
    RX_D_VLD      = 1'b1;
    parity_error  = perr;
    framing_error = ferr;
    last_rx_cyc   = cyc;
    @(posedge Ref_clk); #1;
    RX_D_VLD      = 1'b0;
    parity_error  = 1'b0;
    framing_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Ref_clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge Ref_clk);
    @(negedge Ref_clk);
    check("rst_strobes", {27'd0, WrEn, RdEn, ALU_EN, TX_D_VLD, busy}, 32'd0);
    check("rst_addr", Address, 32'd0);
    check("rst_wrdata", WrData, 32'd0);
    check("rst_alufun", ALU_FUN, 32'd0);
    check("rst_txdata", TX_P_DATA, 32'd0);
    @(posedge Ref_clk); #1;
    RST = 1'b0;
    idle(1);

    // Write AA,05,55 back-to-back
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h55);
    idle(3);
    check("wr_count", wr_addr_log.size(), 32'd1);
    check("wr_addr", wr_addr_log[0], 32'h5);
    check("wr_data", wr_data_log[0], 32'h55);
    check("wr_latency", wr_cyc_log[0], last_rx_cyc + 1);
    check("wr_addr_hold", Address, 32'h5);
    check("wr_no_rd", rd_cnt, 32'd0);

    // Read BB,05 with a byte dropped while busy
    clear_logs();
    send_byte(8'hBB); send_byte(8'h05);
    idle(2);
    check("rd_count", rd_cnt, 32'd1);
    check("rd_addr", rd_addr_last, 32'h5);
    check("rd_busy", busy, 32'd1);
    send_byte(8'hAA);
    idle(2);
    RdData = 8'h55; RdData_Valid = 1'b1; vcyc = cyc;
    idle(1);
    RdData_Valid = 1'b0;
    idle(3);
    check("rd_tx_count", tx_log.size(), 32'd1);
    check("rd_tx_data", tx_log[0], 32'h55);
    check("rd_tx_latency", tx_cyc_log[0], vcyc + 1);
    check("rd_done_busy", busy, 32'd0);
    send_byte(8'h07); send_byte(8'h11);
    idle(3);
    check("busy_drop", wr_addr_log.size(), 32'd0);

    // ALU with operands CC,0A,19,00
    clear_logs();
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h19); send_byte(8'h00);
    idle(3);
    check("aluop_wr_count", wr_addr_log.size(), 32'd2);
    check("aluop_a_addr", wr_addr_log[0], 32'h0);
    check("aluop_a_data", wr_data_log[0], 32'h0A);
    check("aluop_b_addr", wr_addr_log[1], 32'h1);
    check("aluop_b_data", wr_data_log[1], 32'h19);
    check("aluop_en_count", alu_cnt, 32'd1);
    check("aluop_fun", alu_fun_last, 32'h0);
    ALU_OUT = 16'h0023; OUT_Valid = 1'b1; vcyc = cyc;
    idle(1);
    OUT_Valid = 1'b0;
    idle(4);
    check("aluop_tx_count", tx_log.size(), 32'd2);
    check("aluop_tx_lo", tx_log[0], 32'h23);
    check("aluop_tx_hi", tx_log[1], 32'h00);
    check("aluop_tx_lat", tx_cyc_log[0], vcyc + 1);
    check("aluop_tx_gap", tx_cyc_log[1], tx_cyc_log[0] + 1);

    // ALU without operands DD,06
    clear_logs();
    send_byte(8'hDD); send_byte(8'h06);
    idle(3);
    check("alunop_no_wr", wr_addr_log.size(), 32'd0);
    check("alunop_en_count", alu_cnt, 32'd1);
    check("alunop_fun", alu_fun_last, 32'h6);
    ALU_OUT = 16'h00FB; OUT_Valid = 1'b1;
    idle(1);
    OUT_Valid = 1'b0;
    idle(4);
    check("alunop_tx_count", tx_log.size(), 32'd2);
    check("alunop_tx_lo", tx_log[0], 32'hFB);
    check("alunop_tx_hi", tx_log[1], 32'h00);

    // FIFO_FULL for 5 cycles of TX_LO
    clear_logs();
    send_byte(8'hDD); send_byte(8'h00);
    idle(3);
    ALU_OUT = 16'h0023; OUT_Valid = 1'b1; FIFO_FULL = 1'b1; vcyc = cyc;
    idle(1);
    OUT_Valid = 1'b0;
    idle(3);
    check("stall_txdata_stable", TX_P_DATA, 32'h23);
    check("stall_no_vld", TX_D_VLD, 32'd0);
    idle(2);
    check("stall_no_push", tx_log.size(), 32'd0);
    FIFO_FULL = 1'b0;
    idle(4);
    check("stall_tx_count", tx_log.size(), 32'd2);
    check("stall_tx_lo", tx_log[0], 32'h23);
    check("stall_tx_hi", tx_log[1], 32'h00);
    check("stall_release_cyc", tx_cyc_log[0], vcyc + 6);

    // Parity error mid-frame aborts to IDLE
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05); send_byte(8'h55, 1'b1, 1'b0);
    idle(2);
    check("perr_no_wr", wr_addr_log.size(), 32'd0);
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'h77);
    idle(3);
    check("perr_recover_count", wr_addr_log.size(), 32'd1);
    check("perr_recover_addr", wr_addr_log[0], 32'h3);
    check("perr_recover_data", wr_data_log[0], 32'h77);

    // Framing error after operand A keeps reg0 write only
    clear_logs();
    send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h19, 1'b0, 1'b1);
    idle(2);
    send_byte(8'h19); send_byte(8'h00);
    idle(3);
    check("ferr_wr_count", wr_addr_log.size(), 32'd1);
    check("ferr_wr_data", wr_data_log[0], 32'h0A);
    check("ferr_no_alu", alu_cnt, 32'd0);

    // Unknown opcode ignored
    clear_logs();
    send_byte(8'h12); send_byte(8'h05); send_byte(8'h55);
    idle(3);
    check("badop_strobes", wr_addr_log.size() + rd_cnt + alu_cnt, 32'd0);

    // Reset mid-frame
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("midrst_addr", Address, 32'd0);
    send_byte(8'h55);
    idle(3);
    check("midrst_no_wr", wr_addr_log.size(), 32'd0);

    // Long gap between address and data bytes
    clear_logs();
    send_byte(8'hAA); send_byte(8'h05);
    idle(110);
    send_byte(8'h55);
    idle(3);
`ifdef CMD_TIMEOUT_EN
    check("timeout_no_wr", wr_addr_log.size(), 32'd0);
`else
    check("no_timeout_wr", wr_addr_log.size(), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command controller between the UART receiver and the register file, ALU and TX FIFO of the UART-controlled system. It parses received byte frames (write, read, ALU with operands, ALU without operands), drives the register-file and ALU control strobes, and pushes response bytes into the TX FIFO. It is the RX-side consumer of the UART receiver's parallel output. It is also the producer for the TX FIFO that feeds the UART transmitter.

## Interface
Parameters:
- Data_width, 8, byte width of UART payload and register-file data
- Address_width, 4, register-file address width
- TIMEOUT_CYCLES, 65535, inter-byte timeout in Ref_clk cycles (used only with the timeout feature)

Ports (one clock; reset is synchronous and active-high):
- Ref_clk  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous active-high reset
- RX_P_DATA  in  Data_width  received byte
- RX_D_VLD  in  1  one-cycle strobe, RX_P_DATA valid
- parity_error  in  1  qualifies current RX_D_VLD byte
- framing_error  in  1  qualifies current RX_D_VLD byte
- Address  out  Address_width  register-file address
- WrData  out  Data_width  register-file write data
- WrEn  out  1  one-cycle write strobe
- RdEn  out  1  one-cycle read strobe
- RdData  in  Data_width  register-file read data
- RdData_Valid  in  1  RdData valid strobe
- ALU_EN  out  1  one-cycle ALU start strobe
- ALU_FUN  out  4  ALU function code
- ALU_OUT  in  2*Data_width  ALU result
- OUT_Valid  in  1  ALU result valid strobe
- TX_P_DATA  out  Data_width  byte to TX FIFO
- TX_D_VLD  out  1  FIFO write strobe
- FIFO_FULL  in  1  TX FIFO full
- busy  out  1  high in any state other than IDLE and the operand-collect states

## Operation
- Opcodes (first byte in IDLE): 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte ignored, stay IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_RD, TX_LO, TX_HI.
- 0xAA: WR_ADDR latches Address = byte[Address_width-1:0]; WR_DATA byte -> WrData, WrEn pulse, -> IDLE.
- 0xBB: RD_ADDR byte -> Address, RdEn pulse, -> RD_WAIT; on RdData_Valid latch RdData -> TX_RD; push one byte -> IDLE.
- 0xCC: ALU_A byte -> WrEn to Address 0; ALU_B byte -> WrEn to Address 1; -> ALU_FUN.
- 0xDD: directly -> ALU_FUN (ALU uses existing reg0/reg1).
- ALU_FUN: ALU_FUN = byte[3:0], ALU_EN pulse, -> ALU_WAIT; on OUT_Valid latch ALU_OUT -> TX_LO (push ALU_OUT[7:0]) -> TX_HI (push ALU_OUT[15:8]) -> IDLE.
- TX push: TX_D_VLD asserted only in a cycle with FIFO_FULL=0; otherwise state holds, TX_P_DATA stable.
- RX byte with parity_error or framing_error: byte discarded, FSM -> IDLE from any collect state (IDLE, WR_*, RD_ADDR, ALU_A/B/FUN). Partially-collected frame has no effect, except a committed operand write to reg0 (already issued by a prior ALU_A).
- RX_D_VLD while busy: byte dropped, state unchanged.
- RD_WAIT/ALU_WAIT wait indefinitely for their valid strobe (timeout does not apply).

## Timing
- Reset: all outputs 0, state IDLE, latched data cleared; RST mid-frame aborts with no further strobes.
- WrEn/RdEn/ALU_EN: asserted in the cycle after the RX_D_VLD cycle of the triggering byte, exactly one cycle wide; Address/WrData/ALU_FUN valid in the same cycle and held until next update.
- Read response: TX_D_VLD earliest one cycle after RdData_Valid.
- ALU response: low byte earliest one cycle after OUT_Valid, high byte the following cycle; stalls per FIFO_FULL cycle.
- Back-to-back RX_D_VLD on consecutive cycles accepted in collect states.

## Configuration
- CMD_TIMEOUT_EN defined: counter cleared on every accepted byte, increments in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN. When it reaches TIMEOUT_CYCLES, FSM -> IDLE, no strobes.
- Undefined: no counter; collect states wait indefinitely.

## Test plan
- AA,05,55 -> single WrEn with Address=5, WrData=0x55; BB,05 then RdData=0x55 on RdData_Valid -> one TX_D_VLD with TX_P_DATA=0x55.
- CC,0A,19,00 -> WrEn A0=0x0A, WrEn A1=0x19, ALU_EN with ALU_FUN=0; ALU_OUT=0x0023 -> TX 0x23 then 0x00.
- DD,06 -> no WrEn, ALU_EN with ALU_FUN=6; ALU_OUT=0x00FB -> TX 0xFB, 0x00.
- FIFO_FULL high 5 cycles during TX_LO -> no TX_D_VLD for 5 cycles, then 0x23, 0x00 in order, no loss.
- AA,05 then byte with parity_error -> no WrEn, FSM IDLE; next AA,03,77 writes 0x77 to address 3.
- With CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100: AA, 05 then 100 idle cycles -> IDLE, later 55 ignored (no WrEn).
